// File: rtl/riscv_hazard_scoreboard.sv
// riscv_hazard_scoreboard: forwarding and load-use hazard unit.
// Tracks in-flight destinations across NUM_FWD_STAGES post-EX slots and
// produces registered forwarding selects plus a combinational ID stall.
// Optional build macro HAZARD_PERF_EN adds saturating stall/forward counters.
module riscv_hazard_scoreboard #(
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_LAT       = 1,
  localparam int SEL_W         = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_use_rs1,
  input  logic                  i_id_use_rs2,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_reg_write,
  input  logic                  i_id_is_load,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic [SEL_W-1:0]      o_fwd_a,
  output logic [SEL_W-1:0]      o_fwd_b
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           o_stall_cycles,
  output logic [31:0]           o_fwd_events
`endif
);

  // Slot j = instruction j stages past EX (slot 0 is in EX now).
  logic [NUM_FWD_STAGES-1:0]                 r_vld;
  logic [NUM_FWD_STAGES-1:0]                 r_wr;
  logic [NUM_FWD_STAGES-1:0]                 r_ld;
  logic [NUM_FWD_STAGES-1:0][REG_ADDR_W-1:0] r_rd;
  logic [SEL_W-1:0]                          r_fwd_a;
  logic [SEL_W-1:0]                          r_fwd_b;

  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic             w_lu_a;
  logic             w_lu_b;
  logic             w_stall;
  logic             w_issue;

  // Youngest-match search: scan oldest to youngest so the lowest slot wins.
  // A load match is a hazard while its data is not yet forwardable (j < LOAD_LAT).
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_lu_a  = 1'b0;
    w_lu_b  = 1'b0;
    for (int j = NUM_FWD_STAGES - 1; j >= 0; j--) begin
      if (i_id_use_rs1 && r_vld[j] && r_wr[j] && (r_rd[j] != '0) && (r_rd[j] == i_id_rs1)) begin
        w_sel_a = SEL_W'(j + 1);
        w_lu_a  = r_ld[j] && (j < LOAD_LAT);
      end
      if (i_id_use_rs2 && r_vld[j] && r_wr[j] && (r_rd[j] != '0) && (r_rd[j] == i_id_rs2)) begin
        w_sel_b = SEL_W'(j + 1);
        w_lu_b  = r_ld[j] && (j < LOAD_LAT);
      end
    end
  end

  assign w_stall = i_id_valid && !i_flush && (w_lu_a || w_lu_b);
  assign w_issue = i_id_valid && !w_stall && !i_flush;
  assign o_stall = w_stall;
  assign o_fwd_a = r_fwd_a;
  assign o_fwd_b = r_fwd_b;

  // Tracker shift: ID enters slot 0 (or a bubble); a flush also kills the
  // squashed EX entry as it moves into slot 1 so it can never forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_wr  <= '0;
      r_ld  <= '0;
      r_rd  <= '0;
    end else begin
      r_vld[0] <= w_issue;
      r_wr[0]  <= i_id_reg_write;
      r_ld[0]  <= i_id_is_load;
      r_rd[0]  <= i_id_rd;
      for (int j = 1; j < NUM_FWD_STAGES; j++) begin
        r_vld[j] <= (j == 1) ? (r_vld[j-1] && !i_flush) : r_vld[j-1];
        r_wr[j]  <= r_wr[j-1];
        r_ld[j]  <= r_ld[j-1];
        r_rd[j]  <= r_rd[j-1];
      end
    end
  end

  // Selects line up with the consumer reaching EX; bubbles read the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else if (w_issue) begin
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
    end else begin
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_fwd_events;

  // Saturating event counters; they hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_fwd_events   <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (((r_fwd_a != '0) || (r_fwd_b != '0)) && (r_fwd_events != '1))
        r_fwd_events <= r_fwd_events + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_fwd_events   = r_fwd_events;
`endif

endmodule
